// File: rtl/acc_pkg.sv
// Shared definitions for the conv-tile activation/requant path.
package acc_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CLIP   = 2'd3
  } act_mode_e;

  localparam int ACC_LANES = 7;
  localparam int ACC_IW    = 32;
  localparam int ACC_OW    = 8;
  localparam int ACC_SHW   = 5;
  localparam int LEAK_SHW  = 4;
  localparam int SATCNT_W  = 16;

endpackage

// File: rtl/act_lane.sv
// One lane: stage-1 activation + rounding shift, stage-2 saturate/clip.
// Purely combinational; the top owns the registers between the halves.
module act_lane
  import acc_pkg::*;
#(
  parameter int IW  = ACC_IW,
  parameter int OW  = ACC_OW,
  parameter int SHW = ACC_SHW
) (
  input  logic [IW-1:0]       x,
  input  logic [1:0]          mode,
  input  logic [SHW-1:0]      shift,
  input  logic [LEAK_SHW-1:0] leak_sh,
  output logic [IW:0]         r,
  input  logic [IW:0]         r_s2,
  input  logic [1:0]          mode_s2,
  input  logic [OW-1:0]       clip_s2,
  output logic [OW-1:0]       y,
  output logic                sat
);

  localparam logic signed [IW:0] MAXV = (IW+1)'(2**(OW-1) - 1);
  localparam logic signed [IW:0] MINV = ~MAXV;

  logic signed [IW-1:0] xs;
  logic signed [IW-1:0] a;
  logic signed [IW:0]   a_ext;
  logic signed [IW:0]   rnd;
  logic signed [IW:0]   sum;
  logic signed [IW:0]   rs;
  logic        [OW-1:0] ys;

  always_comb begin
    xs = signed'(x);
    case (act_mode_e'(mode))
      ACT_RELU, ACT_CLIP: a = xs[IW-1] ? '0 : xs;
      ACT_LEAKY:          a = xs[IW-1] ? (xs >>> leak_sh) : xs;
      default:            a = xs;
    endcase
    a_ext = {a[IW-1], a};
    // Half-LSB bias; shift==0 yields zero so one path covers both cases.
    rnd   = ((IW+1)'(1) << shift) >> 1;
    sum   = a_ext + rnd;
    r     = sum >>> shift;
  end

  always_comb begin
    rs  = signed'(r_s2);
    sat = 1'b0;
    if (rs > MAXV) begin
      ys  = MAXV[OW-1:0];
      sat = 1'b1;
    end else if (rs < MINV) begin
      ys  = MINV[OW-1:0];
      sat = 1'b1;
    end else begin
      ys  = rs[OW-1:0];
    end
    // Clip value is a non-negative bound; mode-3 results are never negative.
    if (act_mode_e'(mode_s2) == ACT_CLIP && !ys[OW-1] && (ys > clip_s2))
      ys = clip_s2;
    y = ys;
  end

endmodule

// File: rtl/act_quant_pipe.sv
// Two-stage activation + requantisation pipeline with valid/ready flow control.
// Config travels with each beat so it may change on every accepted beat.
module act_quant_pipe
  import acc_pkg::*;
#(
  parameter int LANES = ACC_LANES,
  parameter int IW    = ACC_IW,
  parameter int OW    = ACC_OW,
  parameter int SHW   = ACC_SHW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cfg_mode,
  input  logic [SHW-1:0]        cfg_shift,
  input  logic [LEAK_SHW-1:0]   cfg_leak_sh,
  input  logic [OW-1:0]         cfg_clip,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [LANES*IW-1:0]   s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LANES*OW-1:0]   m_data,
  output logic [SATCNT_W-1:0]   sat_cnt
);

  localparam int RW = IW + 1;

  logic                  v1_q, v1_d;
  logic [LANES*RW-1:0]   r1_q, r1_d;
  logic [1:0]            mode1_q, mode1_d;
  logic [OW-1:0]         clip1_q, clip1_d;
  logic                  m_valid_q, m_valid_d;
  logic [LANES*OW-1:0]   m_data_q, m_data_d;
  logic [SATCNT_W-1:0]   sat_cnt_q, sat_cnt_d;

  logic [LANES*RW-1:0]   r_comb;
  logic [LANES*OW-1:0]   y_comb;
  logic [LANES-1:0]      sat_vec;
  logic [SATCNT_W:0]     sat_sum;
  logic                  en1, en2, accept;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    act_lane #(.IW(IW), .OW(OW), .SHW(SHW)) u_lane (
      .x       (s_data[gi*IW +: IW]),
      .mode    (cfg_mode),
      .shift   (cfg_shift),
      .leak_sh (cfg_leak_sh),
      .r       (r_comb[gi*RW +: RW]),
      .r_s2    (r1_q[gi*RW +: RW]),
      .mode_s2 (mode1_q),
      .clip_s2 (clip1_q),
      .y       (y_comb[gi*OW +: OW]),
      .sat     (sat_vec[gi])
    );
  end

  always_comb begin
    en2    = !m_valid_q || m_ready;
    en1    = !v1_q || en2;
    accept = s_valid && en1;

    v1_d      = v1_q;
    r1_d      = r1_q;
    mode1_d   = mode1_q;
    clip1_d   = clip1_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    sat_cnt_d = sat_cnt_q;

    sat_sum = {1'b0, sat_cnt_q};
    for (int i = 0; i < LANES; i++)
      sat_sum = sat_sum + (SATCNT_W+1)'(sat_vec[i]);

    if (en1) begin
      v1_d = accept;
      if (accept) begin
        r1_d    = r_comb;
        mode1_d = cfg_mode;
        clip1_d = cfg_clip;
      end
    end

    // Output register only changes when it is empty or being drained.
    if (en2) begin
      m_valid_d = v1_q;
      if (v1_q) begin
        m_data_d  = y_comb;
        sat_cnt_d = sat_sum[SATCNT_W] ? {SATCNT_W{1'b1}} : sat_sum[SATCNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      r1_q      <= '0;
      mode1_q   <= '0;
      clip1_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      sat_cnt_q <= '0;
    end else begin
      v1_q      <= v1_d;
      r1_q      <= r1_d;
      mode1_q   <= mode1_d;
      clip1_q   <= clip1_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign s_ready = en1;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign sat_cnt = sat_cnt_q;

endmodule

// File: doc/act_quant_pipe.md
Name: act_quant_pipe

Overview:
- Multi-lane activation and requantisation stage. Sits between the accumulator/BN output of a conv tile and the feature-map write buffer.
- Applies a per-beat selectable activation (bypass, ReLU, leaky-ReLU, clipped ReLU) to LANES signed accumulators.
- Follows the activation with a rounding arithmetic right shift and signed saturation to OW bits.
- Two-stage registered pipeline with valid/ready backpressure.

Parameters:
- LANES, 7, number of parallel channels per beat
- IW, 32, signed input width per lane
- OW, 8, signed output width per lane (OW <= IW)
- SHW, 5, width of requant shift field (max shift 2^SHW-1, must be < IW)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_mode  in  2  0=bypass, 1=ReLU, 2=leaky, 3=clipped ReLU
- cfg_shift  in  SHW  requant right-shift amount
- cfg_leak_sh  in  4  leaky slope: negative x becomes x>>>cfg_leak_sh
- cfg_clip  in  OW  upper clip for mode 3 (treated as non-negative signed)
- s_valid  in  1  input beat valid
- s_ready  out  1  stage can accept a beat
- s_data  in  LANES*IW  lane i at [i*IW +: IW], two's complement
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts
- m_data  out  LANES*OW  lane i at [i*OW +: OW]
- sat_cnt  out  16  count of lane results saturated in stage 2; saturates at 0xFFFF

Behaviour:
- Reset values: all stage data registers, m_data, m_valid, internal v1 and sat_cnt are 0. s_ready is combinational and is therefore 1 out of reset.
- Reset is asynchronous and may assert mid-stream: in-flight beats are discarded. There is no output glitch beyond the async clear.
- Handshake and pipeline control:
  - en2 = !m_valid | m_ready
  - en1 = !v1 | en2
  - s_ready = en1
  - A beat transfers on s_valid & s_ready.
- Stage 1 load and latency:
  - Stage 1 loads on en1 with v1 <= s_valid & s_ready.
  - cfg_* are sampled on the accept cycle and carried with the beat, so config may change every beat.
  - Latency: a beat accepted at edge N is on m_data/m_valid after edge N+1 (2 register stages), provided there is no stall.
- Stage 1, per lane (all signed):
  - Activation a:
    - mode0: a = x
    - mode1: a = x<0 ? 0 : x
    - mode2: a = x<0 ? x>>>leak_sh : x
    - mode3: same as mode1
  - Rounded shift r:
    - sh=0: r = a
    - otherwise: r = (a + 2^(sh-1)) >>> sh, computed in IW+1 bits so no overflow.
  - Rounding is half toward +inf.
- Stage 2, per lane:
  - Saturate r to [-2^(OW-1), 2^(OW-1)-1].
  - In mode3, additionally clamp to at most cfg_clip.
  - The sat flag is set when saturation alters the value. The cfg_clip clamp does not count.
  - sat_cnt += popcount(sat flags) on each beat that enters stage 2, saturating at 0xFFFF.
- Backpressure behaviour:
  - m_valid & !m_ready holds m_data stable.
  - Stage 1 keeps its beat if stage 2 is full.
  - s_ready drops only when both stages are occupied and m_ready=0.
  - No beat is lost or duplicated; order is preserved.
- Simultaneous push into stage 2 and pop of m_data in one cycle: full throughput, 1 beat/cycle.

Decomposition:
- Shared package (acc_pkg), holding:
  - mode encodings: ACT_BYPASS, ACT_RELU, ACT_LEAKY, ACT_CLIP
  - lane width constants and the default LANES/IW/OW values used across the conv tile
- One natural sub-module, act_lane: a single lane's combinational stage-1 math plus stage-2 saturate/clip, with a sat flag. It is instantiated LANES times in a generate loop. Pipeline registers and handshake logic stay in the top.

Test Plan:
All scenarios use LANES=7, IW=32, OW=8.
- mode1, shift0, lanes {-5,100,300,0,-1,127,128} -> m_data {0,100,127,0,0,127,127} two cycles later; sat_cnt +2.
- mode2, leak_sh=2, shift0, lanes {-20,-3,-1,-1024,40,0,-4} -> {-5,-1,-1,-128,40,0,-1}; sat_cnt +1.
- mode0, shift=4, lanes {24,23,-24,-25,8,7,-8} -> {2,1,-1,-2,1,0,0}.
- mode3, clip=6, lanes {10,3,-1,6,7,2000,0} -> {6,3,0,6,6,6,0}; sat_cnt +1 (lane 2000 only).
- Stream 6 beats back-to-back; hold m_ready=0 for 5 cycles after first output -> s_ready low after 2 beats held; on release all 6 beats arrive in order, each exactly once; then 1 beat/cycle throughput.
- Pulse rst_n low with both stages full -> m_valid=0, m_data=0 and sat_cnt=0 immediately (async); first beat accepted after release appears 2 cycles later.
